// File: rtl/omega_update_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : omega_update_ctrl                                          |
// | Description : Captures new 40-bit omega words, normalises them by right  |
// |               shifts into the 28-bit sigma-delta increment and commits   |
// |               increment + divider exponent together on a divided-clock   |
// |               tick (or after a tick timeout).                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   CLK67MHZ     in   1  single clock, rising edge                          |
// |   resetPort    in   1  asynchronous active-low reset                      |
// |   omega_in     in  40  candidate frequency word                          |
// |   omega_valid  in   1  single-cycle pulse qualifying omega_in            |
// |   sd_tick      in   1  one pulse per divided-clock rising edge           |
// |   kin_out      out 28  committed sigma-delta increment                   |
// |   div_out      out  4  committed divider exponent (MAX_SHIFT - shifts)   |
// |   commit       out  1  pulse in the cycle kin_out/div_out change         |
// |   busy         out  1  update in flight                                  |
// |   timeout_flag out  1  sticky, set on a forced (tick-less) commit        |
// +--------------------------------------------------------------------------+
module omega_update_ctrl #(
   parameter int MAX_SHIFT    = 12,
   parameter int TICK_TIMEOUT = 4096
) (
   input  logic        CLK67MHZ,
   input  logic        resetPort,
   input  logic [39:0] omega_in,
   input  logic        omega_valid,
   input  logic        sd_tick,
   output logic [27:0] kin_out,
   output logic [3:0]  div_out,
   output logic        commit,
   output logic        busy,
   output logic        timeout_flag
);

   localparam int TO_W = (TICK_TIMEOUT > 1) ? $clog2(TICK_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] c_to_last   = TO_W'(TICK_TIMEOUT - 1);
   localparam logic [3:0]      c_max_shift = 4'(MAX_SHIFT);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SHIFT     = 2'd1,
      WAIT_TICK = 2'd2,
      COMMIT    = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [39:0]       r_work;
   logic [39:0]       w_work_nxt;
   logic [39:0]       r_last_acc;
   logic [39:0]       w_last_acc_nxt;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_nxt;
   logic [TO_W-1:0]   r_to_cnt;
   logic [TO_W-1:0]   w_to_cnt_nxt;
   logic [27:0]       r_kin;
   logic [27:0]       w_kin_nxt;
   logic [3:0]        r_div;
   logic [3:0]        w_div_nxt;
   logic              r_commit;
   logic              w_commit_nxt;
   logic              r_timeout;
   logic              w_timeout_nxt;

   logic              w_new_word;
   logic              w_fits;

   // A word equal to the last accepted one is a duplicate and never
   // starts (or restarts) an update.
   assign w_new_word = omega_valid && (omega_in != r_last_acc);
   assign w_fits     = (r_work[39:28] == 12'd0);

   assign kin_out      = r_kin;
   assign div_out      = r_div;
   assign commit       = r_commit;
   assign timeout_flag = r_timeout;
   assign busy         = (r_state != IDLE);

   always_ff @(posedge CLK67MHZ or negedge resetPort) begin
      if (!resetPort) begin
         r_state    <= IDLE;
         r_work     <= '0;
         r_last_acc <= '0;
         r_cnt      <= '0;
         r_to_cnt   <= '0;
         r_kin      <= '0;
         r_div      <= c_max_shift;
         r_commit   <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_work     <= w_work_nxt;
         r_last_acc <= w_last_acc_nxt;
         r_cnt      <= w_cnt_nxt;
         r_to_cnt   <= w_to_cnt_nxt;
         r_kin      <= w_kin_nxt;
         r_div      <= w_div_nxt;
         r_commit   <= w_commit_nxt;
         r_timeout  <= w_timeout_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_work_nxt     = r_work;
      w_last_acc_nxt = r_last_acc;
      w_cnt_nxt      = r_cnt;
      w_to_cnt_nxt   = r_to_cnt;
      w_kin_nxt      = r_kin;
      w_div_nxt      = r_div;
      w_commit_nxt   = 1'b0;
      w_timeout_nxt  = r_timeout;

      case (r_state)
         IDLE: begin
            w_state_nxt = IDLE;
         end
         SHIFT: begin
            if (!w_fits) begin
               w_work_nxt = r_work >> 1;
               w_cnt_nxt  = r_cnt + 4'd1;
            end else begin
               w_to_cnt_nxt = '0;
               w_state_nxt  = WAIT_TICK;
            end
         end
         WAIT_TICK: begin
            // A new word outranks both the tick and the timeout, so the
            // flag must not be set when a restart happens in this cycle.
            if (!w_new_word) begin
               if (sd_tick) begin
                  w_state_nxt = COMMIT;
               end else if (r_to_cnt == c_to_last) begin
                  w_timeout_nxt = 1'b1;
                  w_state_nxt   = COMMIT;
               end else begin
                  w_to_cnt_nxt = r_to_cnt + TO_W'(1);
               end
            end
         end
         COMMIT: begin
            // The commit always completes, even if a new word arrives now.
            w_kin_nxt    = r_work[27:0];
            w_div_nxt    = c_max_shift - r_cnt;
            w_commit_nxt = 1'b1;
            w_state_nxt  = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // Latest word wins from every state: recapture and renormalise.
      if (w_new_word) begin
         w_work_nxt     = omega_in;
         w_last_acc_nxt = omega_in;
         w_cnt_nxt      = '0;
         w_state_nxt    = SHIFT;
      end
   end

   // 40 - 28 = 12 bits of headroom bound the shift count.
   a_cnt_bound: assert property (@(posedge CLK67MHZ) disable iff (!resetPort)
      r_cnt <= c_max_shift);

endmodule
`default_nettype wire

// File: tb/tb_omega_update_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_omega_update_ctrl                                       |
// | Description : Self-checking bench for omega_update_ctrl: directed vector |
// |               table, hand-written corner sequences and a randomized      |
// |               phase checked against a transaction-level reference model. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_omega_update_ctrl;

   localparam int TO = 16;

   logic        CLK67MHZ;
   logic        resetPort;
   logic [39:0] omega_in;
   logic        omega_valid;
   logic        sd_tick;
   logic [27:0] kin_out;
   logic [3:0]  div_out;
   logic        commit;
   logic        busy;
   logic        timeout_flag;

   int n_checks = 0;
   int n_fail   = 0;

   omega_update_ctrl #(
      .MAX_SHIFT   (12),
      .TICK_TIMEOUT(TO)
   ) dut (
      .CLK67MHZ    (CLK67MHZ),
      .resetPort   (resetPort),
      .omega_in    (omega_in),
      .omega_valid (omega_valid),
      .sd_tick     (sd_tick),
      .kin_out     (kin_out),
      .div_out     (div_out),
      .commit      (commit),
      .busy        (busy),
      .timeout_flag(timeout_flag)
   );

   initial CLK67MHZ = 1'b0;
   always #5 CLK67MHZ = ~CLK67MHZ;

   typedef struct {
      logic [39:0] omega;
      logic [27:0] kin;
      logic [3:0]  div;
      int          lat;
   } vec_t;

   // reference model state
   logic [39:0] m_last;
   logic [39:0] m_word;
   bit          m_pend;
   longint      m_t0;
   int          m_k;
   longint      m_due;
   logic [27:0] m_due_kin;
   logic [3:0]  m_due_div;
   logic [27:0] m_kin;
   logic [3:0]  m_div;
   bit          m_flag;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int shifts_needed(input logic [39:0] w);
      logic [39:0] x;
      int k;
      x = w;
      k = 0;
      while (x > 40'h00_0FFF_FFFF) begin
         x = x / 2;
         k++;
      end
      return k;
   endfunction

   task automatic do_reset();
      resetPort   = 1'b0;
      omega_valid = 1'b0;
      omega_in    = '0;
      sd_tick     = 1'b0;
      repeat (3) @(posedge CLK67MHZ);
      @(negedge CLK67MHZ);
      resetPort = 1'b1;
   endtask

   // Single-cycle valid pulse sampled at the next rising edge.
   task automatic pulse(input logic [39:0] w);
      omega_in    = w;
      omega_valid = 1'b1;
      @(posedge CLK67MHZ);
      #1;
      omega_valid = 1'b0;
   endtask

   // Edges after the valid edge until commit is seen (0 = never within bound).
   task automatic wait_commit(input int bound, output int lat);
      lat = 0;
      for (int i = 1; i <= bound && lat == 0; i++) begin
         @(posedge CLK67MHZ);
         #1;
         if (commit) lat = i;
      end
   endtask

   task automatic count_commits(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge CLK67MHZ);
         #1;
         if (commit) n++;
      end
   endtask

   task automatic model_init();
      m_last = '0; m_word = '0; m_pend = 0; m_t0 = 0; m_k = 0;
      m_due = -1; m_due_kin = '0; m_due_div = 4'd12;
      m_kin = '0; m_div = 4'd12; m_flag = 0;
   endtask

   // Transaction view: an accepted word at edge t needs k shifts; ticks
   // count from edge t+k+2, and the last chance is edge t+k+1+TO.
   task automatic model_step(input longint n, input logic v, input logic [39:0] w,
                             input logic tk, output logic exp_c, output logic exp_b);
      longint first_edge;
      longint last_edge;
      exp_c = 1'b0;
      if (m_due == n) begin
         m_kin = m_due_kin;
         m_div = m_due_div;
         exp_c = 1'b1;
      end
      if (v && (w != m_last)) begin
         m_last = w;
         m_word = w;
         m_k    = shifts_needed(w);
         m_t0   = n;
         m_pend = 1;
      end else if (m_pend) begin
         first_edge = m_t0 + m_k + 2;
         last_edge  = m_t0 + m_k + 1 + TO;
         if (n >= first_edge && (tk || n == last_edge)) begin
            m_due     = n + 1;
            m_due_kin = 28'(m_word >> m_k);
            m_due_div = 4'(12 - m_k);
            if (!tk) m_flag = 1;
            m_pend = 0;
         end
      end
      exp_b = m_pend || (m_due == n + 1);
   endtask

   function automatic logic [39:0] rand_word();
      logic [63:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 5))
         0:       return m_last;
         1:       return 40'h0;
         default: return r[39:0] >> $urandom_range(0, 39);
      endcase
   endfunction

   initial begin
      vec_t vecs[6];
      int   lat;
      int   ncom;
      logic ec;
      logic eb;
      logic v;
      logic tk;
      logic [39:0] w;

      vecs[0] = '{40'h00_0123_4567, 28'h012_3456_7 >> 0, 4'd12, 3};
      vecs[0].kin = 28'h123_4567;
      vecs[1] = '{40'h80_0000_0000, 28'h800_0000, 4'd0,  15};
      vecs[2] = '{40'h00_1000_0000, 28'h800_0000, 4'd11, 4};
      vecs[3] = '{40'hFF_FFFF_FFFF, 28'hFFF_FFFF, 4'd0,  15};
      vecs[4] = '{40'h01_0000_0000, 28'h800_0000, 4'd7,  8};
      vecs[5] = '{40'h00_0FFF_FFFF, 28'hFFF_FFFF, 4'd12, 3};

      do_reset();
      #1;
      chk("rst_kin",  kin_out, 28'h0);
      chk("rst_div",  div_out, 4'd12);
      chk("rst_commit", commit, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_flag", timeout_flag, 1'b0);

      // directed table, tick held high
      sd_tick = 1'b1;
      @(negedge CLK67MHZ);
      for (int i = 0; i < 6; i++) begin
         pulse(vecs[i].omega);
         chk("tbl_busy", busy, 1'b1);
         wait_commit(40, lat);
         chk("tbl_latency", lat, vecs[i].lat);
         chk("tbl_kin", kin_out, vecs[i].kin);
         chk("tbl_div", div_out, vecs[i].div);
         @(posedge CLK67MHZ);
         #1;
         chk("tbl_single_pulse", commit, 1'b0);
         chk("tbl_idle", busy, 1'b0);
      end

      // restart while in WAIT_TICK; the new valid coincides with a tick
      sd_tick = 1'b0;
      pulse(40'h01_0000_0000);
      repeat (9) @(posedge CLK67MHZ);
      #1;
      chk("rs_no_early_commit", commit, 1'b0);
      sd_tick = 1'b1;
      pulse(40'h00_0000_1000);
      count_commits(30, ncom);
      chk("rs_one_commit", ncom, 1);
      chk("rs_kin", kin_out, 28'h000_1000);
      chk("rs_div", div_out, 4'd12);

      // duplicate word
      pulse(40'h12_3456_789A);
      count_commits(25, ncom);
      chk("dup_first_commit", ncom, 1);
      pulse(40'h12_3456_789A);
      chk("dup_busy_low", busy, 1'b0);
      count_commits(25, ncom);
      chk("dup_no_commit", ncom, 0);

      // forced commit with no tick
      sd_tick = 1'b0;
      pulse(40'h00_0000_0055);
      wait_commit(60, lat);
      chk("to_latency", lat, 2 + TO);
      chk("to_flag", timeout_flag, 1'b1);
      chk("to_kin", kin_out, 28'h55);
      chk("to_div", div_out, 4'd12);
      sd_tick = 1'b1;
      pulse(40'h00_0000_0066);
      wait_commit(40, lat);
      chk("to_next_latency", lat, 3);
      chk("to_flag_sticky", timeout_flag, 1'b1);

      // asynchronous reset in the middle of SHIFT
      pulse(40'hFF_0000_0000);
      repeat (3) @(posedge CLK67MHZ);
      #2;
      chk("mid_busy_before", busy, 1'b1);
      resetPort = 1'b0;
      #1;
      chk("arst_kin", kin_out, 28'h0);
      chk("arst_div", div_out, 4'd12);
      chk("arst_commit", commit, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_flag", timeout_flag, 1'b0);
      @(negedge CLK67MHZ);
      resetPort = 1'b1;
      pulse(40'h0);
      chk("zero_dup_busy", busy, 1'b0);
      count_commits(25, ncom);
      chk("arst_no_commit", ncom, 0);

      // randomized phase against the reference model
      do_reset();
      model_init();
      #1;
      for (int c = 0; c < 4000; c++) begin
         v  = ($urandom_range(0, 11) == 0);
         w  = rand_word();
         tk = ($urandom_range(0, 5) == 0);
         omega_valid = v;
         omega_in    = w;
         sd_tick     = tk;
         @(posedge CLK67MHZ);
         model_step(longint'(c), v, w, tk, ec, eb);
         #1;
         chk("rnd_commit", commit, ec);
         chk("rnd_busy", busy, eb);
         chk("rnd_kin", kin_out, m_kin);
         chk("rnd_div", div_out, m_div);
         chk("rnd_flag", timeout_flag, m_flag);
      end
      omega_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/omega_update_ctrl.md
# omega_update_ctrl

Sequences frequency-word updates into the sigma-delta synthesis path. Captures each new 40-bit omega word from the SPI receiver and normalises it by iterative right shifts until it fits the 28-bit sigma-delta input, which yields a clock-divider exponent. It commits the normalised increment and the divider setting together, on the divided-clock boundary, so the modulator never runs with a mismatched increment/divider pair. Sits between `getOmega` and the `clkDivider` / `sigma_delta_twopiece` pair and replaces free-running normalisation.

## Interface
- `MAX_SHIFT`, 12, maximum right shifts; also the divider exponent when no shifts are needed.
- `TICK_TIMEOUT`, 4096, CLK67MHZ cycles to wait for `sd_tick` before forcing the commit.
- `CLK67MHZ` in 1: the single clock; all logic is on its rising edge.
- `resetPort` in 1: asynchronous, active-low reset.
- `omega_in` in 40: candidate frequency word from the SPI receiver.
- `omega_valid` in 1: single-cycle pulse marking `omega_in` as new.
- `sd_tick` in 1: single-cycle pulse, synchronous to CLK67MHZ, asserted once per divided-clock rising edge.
- `kin_out` out 28: committed sigma-delta increment.
- `div_out` out 4: committed divider exponent, equal to `MAX_SHIFT` minus the shift count.
- `commit` out 1: single-cycle pulse in the cycle `kin_out` / `div_out` change.
- `busy` out 1: high while an update is in flight (all states except IDLE).
- `timeout_flag` out 1: sticky; set on a forced commit and cleared only by reset.

## Operation
- States are IDLE, SHIFT, WAIT_TICK and COMMIT.
- **IDLE**
  - On `omega_valid`, if `omega_in` differs from `last_acc`: capture `omega_in` into `work`, copy it to `last_acc`, clear `cnt`, go to SHIFT.
  - On `omega_valid` with an identical word: ignore it. `busy` stays low and no commit occurs.
- **SHIFT**
  - If `work[39:28] != 0`: `work <= work >> 1`, `cnt <= cnt + 1`.
  - Otherwise: clear the timeout counter and go to WAIT_TICK.
  - `cnt` never exceeds `MAX_SHIFT`; 40 − 12 = 28 guarantees this. Assertion: `cnt <= MAX_SHIFT`.
- **WAIT_TICK**
  - On `sd_tick`, go to COMMIT.
  - Otherwise increment the timeout counter. At `TICK_TIMEOUT - 1`, set `timeout_flag` and go to COMMIT.
- **COMMIT** (one cycle)
  - `kin_out <= work[27:0]`, `div_out <= MAX_SHIFT - cnt`, `commit <= 1`, go to IDLE.
- **Restart rule**: `omega_valid` with a word that differs from `last_acc` in SHIFT or WAIT_TICK recaptures, clears `cnt`, and returns to SHIFT. The pending update is discarded (latest wins).
- **Simultaneous events**
  - `omega_valid` and `sd_tick` in the same WAIT_TICK cycle: `omega_valid` wins.
  - `omega_valid` during COMMIT: the commit completes, and the new word is captured in the same edge. The next state is SHIFT, not IDLE.
- **Reset (asynchronous, any state)**
  - State returns to IDLE.
  - `kin_out=0`, `div_out=MAX_SHIFT` (12), `commit=0`, `busy=0`, `timeout_flag=0`.
  - `last_acc=0`, `work=0`, `cnt=0`.
  - An omega of 0 after reset is therefore treated as a duplicate.

## Timing
- `omega_valid` at edge t: `busy` is high after t, and SHIFT occupies cycles t+1 … t+k+1 for k shifts (k+1 cycles).
- WAIT_TICK is entered at edge t+k+2.
- With `sd_tick` present at cycle t+k+2, COMMIT is at t+k+3, and `commit` / outputs update at edge t+k+3.
- Minimum latency from `omega_valid` to `commit` is 3 cycles (k=0, immediate tick).
- Worst case without a tick is k+2+`TICK_TIMEOUT` cycles.
- `kin_out` and `div_out` change only on the `commit` cycle and are always updated together.
- `commit` is never asserted for two consecutive cycles.

## Test plan
- Reset mid-SHIFT with `omega_in=40'hFF_0000_0000`: all outputs at reset values immediately (asynchronous); no `commit` afterwards.
- `omega_in=40'h00_0123_4567`, tick held high: k=0, `commit` 3 cycles after valid, `kin_out=28'h0123_4567`, `div_out=12`.
- `omega_in=40'h80_0000_0000`: k=12, `kin_out=28'h800_0000`, `div_out=0`, commit at t+15 with tick high.
- Second valid with `40'h00_0000_1000` while WAIT_TICK holds `40'h01_0000_0000`: the first update is dropped; the single commit gives `kin_out=28'h000_1000`, `div_out=12`.
- Same word sent twice: exactly one `commit`; `busy` stays low for the second pulse.
- `sd_tick` held low, `TICK_TIMEOUT=16`: forced commit at t+k+2+16, and `timeout_flag` stays set until reset.
